// File: rtl/stopwatch_ctrl_dp.sv
// Stopwatch control FSM and binary hh:mm:ss.cc time datapath with a tick
// divider that pauses (not resets) while stopped and selectable count direction.
module stopwatch_ctrl_dp #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_run_stop,
    input  logic       i_clear,
    input  logic       i_up,
    input  logic       i_down,
    output logic [6:0] o_cc,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic       o_run,
    output logic       o_dir
);

    localparam int DIV   = CLK_FREQ / TICK_HZ;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic [1:0] {
        S_STOP  = 2'd0,
        S_RUN   = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [6:0]       cc_q, cc_d;
    logic [5:0]       sec_q, sec_d;
    logic [5:0]       min_q, min_d;
    logic [4:0]       hour_q, hour_d;
    logic             run_q, run_d;
    logic             dir_q, dir_d;

    logic tick;
    logic cc_end, sec_end, min_end, hour_end;
    logic sec_adv, min_adv, hour_adv;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_STOP;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_STOP: begin
                if (i_clear) begin
                    state_d = S_CLEAR;
                end else if (i_run_stop) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (i_run_stop) begin
                    state_d = S_STOP;
                end
            end
            S_CLEAR: state_d = S_STOP;
            default: state_d = S_STOP;
        endcase
    end

    assign run_d = (state_d == S_RUN);

    // Simultaneous up/down pulses cancel and leave the direction as it was.
    always_comb begin
        dir_d = dir_q;
        if (i_up && !i_down) begin
            dir_d = 1'b0;
        end else if (i_down && !i_up) begin
            dir_d = 1'b1;
        end
    end

    // ---------------- tick divider ----------------
    assign tick = (state_q == S_RUN) && (div_q == DIV_LAST);

    always_comb begin
        div_d = div_q;
        if (state_q == S_CLEAR) begin
            div_d = '0;
        end else if (state_q == S_RUN) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end
    end

    // ---------------- time datapath ----------------
    // A field "ends" when its next step would wrap in the current direction.
    assign cc_end   = dir_q ? (cc_q == 7'd0)   : (cc_q == 7'd99);
    assign sec_end  = dir_q ? (sec_q == 6'd0)  : (sec_q == 6'd59);
    assign min_end  = dir_q ? (min_q == 6'd0)  : (min_q == 6'd59);
    assign hour_end = dir_q ? (hour_q == 5'd0) : (hour_q == 5'd23);

    assign sec_adv  = tick && cc_end;
    assign min_adv  = sec_adv && sec_end;
    assign hour_adv = min_adv && min_end;

    always_comb begin
        cc_d   = cc_q;
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        if (state_q == S_CLEAR) begin
            cc_d   = '0;
            sec_d  = '0;
            min_d  = '0;
            hour_d = '0;
        end else begin
            if (tick) begin
                if (cc_end) begin
                    cc_d = dir_q ? 7'd99 : 7'd0;
                end else begin
                    cc_d = dir_q ? cc_q - 7'd1 : cc_q + 7'd1;
                end
            end
            if (sec_adv) begin
                if (sec_end) begin
                    sec_d = dir_q ? 6'd59 : 6'd0;
                end else begin
                    sec_d = dir_q ? sec_q - 6'd1 : sec_q + 6'd1;
                end
            end
            if (min_adv) begin
                if (min_end) begin
                    min_d = dir_q ? 6'd59 : 6'd0;
                end else begin
                    min_d = dir_q ? min_q - 6'd1 : min_q + 6'd1;
                end
            end
            if (hour_adv) begin
                if (hour_end) begin
                    hour_d = dir_q ? 5'd23 : 5'd0;
                end else begin
                    hour_d = dir_q ? hour_q - 5'd1 : hour_q + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            cc_q   <= '0;
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= '0;
            run_q  <= 1'b0;
            dir_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            cc_q   <= cc_d;
            sec_q  <= sec_d;
            min_q  <= min_d;
            hour_q <= hour_d;
            run_q  <= run_d;
            dir_q  <= dir_d;
        end
    end

    assign o_cc   = cc_q;
    assign o_sec  = sec_q;
    assign o_min  = min_q;
    assign o_hour = hour_q;
    assign o_run  = run_q;
    assign o_dir  = dir_q;

endmodule

// File: tb/tb_stopwatch_ctrl_dp.sv
// Scoreboard bench: stimulus pushes expected snapshots tagged with a cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_stopwatch_ctrl_dp;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_run_stop = 1'b0;
    logic       i_clear = 1'b0;
    logic       i_up = 1'b0;
    logic       i_down = 1'b0;
    logic [6:0] o_cc;
    logic [5:0] o_sec;
    logic [5:0] o_min;
    logic [4:0] o_hour;
    logic       o_run;
    logic       o_dir;

    stopwatch_ctrl_dp #(.CLK_FREQ(1000), .TICK_HZ(100)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_run_stop(i_run_stop),
        .i_clear   (i_clear),
        .i_up      (i_up),
        .i_down    (i_down),
        .o_cc      (o_cc),
        .o_sec     (o_sec),
        .o_min     (o_min),
        .o_hour    (o_hour),
        .o_run     (o_run),
        .o_dir     (o_dir)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         target;
        logic [25:0] exp;
    } item_t;

    item_t queue_q[$];
    int    cyc = 0;
    int    tests = 0;
    int    fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every negedge, compare any snapshot due in this cycle.
    always @(negedge clk) begin
        logic [25:0] got;
        item_t it;
        got = {o_cc, o_sec, o_min, o_hour, o_run, o_dir};
        while (queue_q.size() > 0 && queue_q[0].target <= cyc) begin
            it = queue_q.pop_front();
            tests = tests + 1;
            if (it.target < cyc) begin
                fails = fails + 1;
                $display("[TB] FAIL %s: snapshot stale (due cycle %0d, now %0d)", it.name, it.target, cyc);
            end else if (got !== it.exp) begin
                fails = fails + 1;
                $display("[TB] FAIL %s: got %0d:%0d:%0d.%0d run=%0d dir=%0d, required %0d:%0d:%0d.%0d run=%0d dir=%0d",
                         it.name, o_hour, o_min, o_sec, o_cc, o_run, o_dir,
                         it.exp[6:2], it.exp[12:7], it.exp[18:13], it.exp[25:19], it.exp[1], it.exp[0]);
            end else begin
                $display("[TB] ok %s: %0d:%0d:%0d.%0d run=%0d dir=%0d",
                         it.name, o_hour, o_min, o_sec, o_cc, o_run, o_dir);
            end
        end
    end

    task automatic expect_now(input string name, input int hr, input int mn, input int sc,
                              input int cc, input bit run, input bit dir);
        item_t it;
        it.name   = name;
        it.target = cyc;
        it.exp    = {7'(cc), 6'(sc), 6'(mn), 5'(hr), run, dir};
        queue_q.push_back(it);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive the selected pulse lines for exactly one sampling edge.
    task automatic pulse(input bit rs, input bit clr, input bit up, input bit dn);
        i_run_stop = rs;
        i_clear    = clr;
        i_up       = up;
        i_down     = dn;
        step(1);
        i_run_stop = 1'b0;
        i_clear    = 1'b0;
        i_up       = 1'b0;
        i_down     = 1'b0;
    endtask

    initial begin
        step(2);
        rst = 1'b0;
        expect_now("reset", 0, 0, 0, 0, 0, 0);

        pulse(1, 0, 0, 0);
        expect_now("run_start", 0, 0, 0, 0, 1, 0);
        step(9);
        expect_now("no_tick_9", 0, 0, 0, 0, 1, 0);
        step(1);
        expect_now("first_tick", 0, 0, 0, 1, 1, 0);
        step(40);
        expect_now("cc5", 0, 0, 0, 5, 1, 0);
        step(950);
        expect_now("cc_carry_sec", 0, 0, 1, 0, 1, 0);

        // stop with the divider at 4, hold, resume: tick after 6 RUN cycles
        step(3);
        pulse(1, 0, 0, 0);
        expect_now("stop_div4", 0, 0, 1, 0, 0, 0);
        step(100);
        expect_now("hold_100", 0, 0, 1, 0, 0, 0);
        pulse(1, 0, 0, 0);
        step(5);
        expect_now("resume_5", 0, 0, 1, 0, 1, 0);
        step(1);
        expect_now("resume_tick6", 0, 0, 1, 1, 1, 0);

        pulse(0, 0, 0, 1);
        expect_now("dir_down", 0, 0, 1, 1, 1, 1);
        step(9);
        expect_now("down_tick", 0, 0, 1, 0, 1, 1);
        step(10);
        expect_now("sec_borrow", 0, 0, 0, 99, 1, 1);
        step(9);
        pulse(1, 0, 0, 0);
        expect_now("tick_with_stop", 0, 0, 0, 98, 0, 1);

        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        expect_now("clear_in_run", 0, 0, 0, 98, 1, 1);
        pulse(1, 0, 0, 0);
        expect_now("stopped_again", 0, 0, 0, 98, 0, 1);
        pulse(0, 0, 1, 0);
        expect_now("up_in_stop", 0, 0, 0, 98, 0, 0);
        pulse(0, 1, 0, 0);
        expect_now("in_clear", 0, 0, 0, 98, 0, 0);
        step(1);
        expect_now("cleared", 0, 0, 0, 0, 0, 0);
        pulse(0, 0, 0, 1);
        pulse(1, 0, 0, 0);
        step(9);
        expect_now("down_pre", 0, 0, 0, 0, 1, 1);
        step(1);
        expect_now("down_wrap", 23, 59, 59, 99, 1, 1);

        pulse(0, 0, 1, 0);
        step(8);
        expect_now("up_pre", 23, 59, 59, 99, 1, 0);
        step(1);
        expect_now("up_wrap", 0, 0, 0, 0, 1, 0);

        pulse(0, 0, 1, 1);
        expect_now("updown_keep0", 0, 0, 0, 0, 1, 0);
        pulse(0, 0, 0, 1);
        pulse(0, 0, 1, 1);
        expect_now("updown_keep1", 0, 0, 0, 0, 1, 1);

        pulse(1, 0, 0, 0);
        pulse(1, 1, 0, 0);
        expect_now("clr_wins", 0, 0, 0, 0, 0, 1);
        step(1);
        expect_now("clr_to_stop", 0, 0, 0, 0, 0, 1);
        step(5);
        expect_now("still_stop", 0, 0, 0, 0, 0, 1);

        // divider must have been zeroed by CLEAR for this to land exactly
        pulse(0, 0, 1, 0);
        pulse(1, 0, 0, 0);
        step(3470);
        expect_now("t3_47", 0, 0, 3, 47, 1, 0);
        step(5);
        pulse(0, 0, 0, 1);
        expect_now("pre_reset", 0, 0, 3, 47, 1, 1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        expect_now("mid_reset", 0, 0, 0, 0, 0, 0);
        step(20);
        expect_now("post_reset", 0, 0, 0, 0, 0, 0);

        begin
            int guard;
            guard = 0;
            while (queue_q.size() > 0 && guard < 20) begin
                step(1);
                guard = guard + 1;
            end
            if (queue_q.size() > 0) begin
                tests = tests + 1;
                fails = fails + 1;
                $display("[TB] FAIL drain: %0d snapshots left, required 0", queue_q.size());
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl_dp.md
Name: stopwatch_ctrl_dp

Overview:
- Consumes the single-cycle debounced button pulses for run/stop, clear, up and down, and implements a stopwatch: a control FSM plus a BCD-free binary time counter.
- Time format is hh:mm:ss.cc (centiseconds). Counting direction is selectable.
- Outputs feed the FND/display formatter downstream.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- TICK_HZ, 100, count rate in Hz. DIV = CLK_FREQ/TICK_HZ; DIV is an integer ≥ 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- i_run_stop  input  1  debounced 1-cycle pulse; toggles run/stop.
- i_clear  input  1  debounced 1-cycle pulse; zeroes time when stopped.
- i_up  input  1  debounced 1-cycle pulse; selects up-count.
- i_down  input  1  debounced 1-cycle pulse; selects down-count.
- o_cc  output  7  centiseconds, 0..99.
- o_sec  output  6  seconds, 0..59.
- o_min  output  6  minutes, 0..59.
- o_hour  output  5  hours, 0..23.
- o_run  output  1  1 while in RUN.
- o_dir  output  1  0 = up, 1 = down.

Behaviour:
- Reset: synchronous and active-high. On the clock edge with rst=1, the FSM goes to STOP and all of the following clear to 0: the divider, o_cc, o_sec, o_min, o_hour, o_run and o_dir.
- Reset has priority over all inputs, including in the middle of a count.
- All outputs are registered.

FSM:
- States are STOP, RUN and CLEAR. Transitions are decided on the registered state.
- STOP: i_clear=1 → CLEAR, otherwise i_run_stop=1 → RUN. If both arrive together, clear wins.
- RUN: i_run_stop=1 → STOP. i_clear is ignored in RUN.
- CLEAR: lasts exactly 1 cycle. It zeroes the time registers and the divider, then goes unconditionally to STOP. Pulses arriving during CLEAR are ignored, except i_up/i_down.
- o_run = 1 exactly when the state is RUN. It changes on the edge after the pulse cycle.

Divider:
- Counts 0..DIV-1 only while state = RUN; it holds its value in STOP.
- tick = (state==RUN && div==DIV-1). On a tick, div returns to 0 and time advances on the same edge.
- Because the divider holds, a stop/resume cycle loses no partial tick.
- The tick uses the registered state. A tick in the same cycle as an i_run_stop pulse in RUN is still applied.

Up-count (o_dir=0):
- cc increments. At 99, cc→0 with a carry into sec.
- sec 59→0 carries into min; min 59→0 carries into hour; hour 23→0.
- 23:59:59.99 wraps to 00:00:00.00.

Down-count (o_dir=1):
- cc decrements. At 0, cc→99 with a borrow from sec.
- sec 0→59, min 0→59, hour 0→23.
- 00:00:00.00 wraps to 23:59:59.99.

Direction control:
- i_up=1 sets o_dir to 0; i_down=1 sets o_dir to 1. Both are accepted in any state.
- i_up and i_down in the same cycle leave o_dir unchanged.
- A direction change takes effect from the next tick onwards.
- CLEAR does not change o_dir.

Width rules:
- No field ever leaves its legal range; every update is explicit compare-and-wrap.

Test Plan:
- Use CLK_FREQ=1000 and TICK_HZ=100, so DIV=10.
- Reset and run: rst for 2 cycles, then an i_run_stop pulse → o_run=1 one cycle later; o_cc=1 after the 10th RUN cycle, and o_cc=5 after 50 RUN cycles.
- Carry chain: run up-count to 00:00:59.99, then 1 more tick → 00:01:00.00. Force a run to 23:59:59.99, then 1 tick → 00:00:00.00.
- Down-count: stopped at 0 → i_down pulse → run; after 10 cycles → 23:59:59.99, o_dir=1.
- Stop/resume/clear: stop at div=4 → hold 100 cycles with no change → resume; first tick arrives 6 cycles later. Then stop and pulse i_clear → all fields 0 and div 0, o_dir preserved, state STOP.
- Priority: i_clear during RUN → no effect. i_run_stop and i_clear together in STOP → state CLEAR then STOP, o_run stays 0. i_up and i_down together → o_dir unchanged.
- Reset mid-count: assert rst while RUN at 00:00:03.47 → next edge gives all outputs 0, STOP, o_dir=0.
